id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core, directly downstream of the ID-stage forwarding detector.
- Consumes its forward_rs1/forward_rs2 select codes and picks each operand from the register file, the EX-stage ALU result or the MEM-stage writeback value.
- Latches the selected operands plus decoded control into the EX stage, inserting bubbles on stall/flush.
- Resolves ECALL halt using the forwarded x17 value and keeps saturating stall/flush event counters for the testbench.

Parameters:
XLEN, 32, datapath width
CNT_WIDTH, 32, width of each event counter
HALT_CODE, 10, ECALL rs1 value that means halt

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
is_stall  input  1  load-use/ecall stall from hazard unit: load a bubble, ID holds
is_flush  input  1  branch-mispredict flush: load a bubble
ID_valid  input  1  ID holds a real instruction
ID_pc  input  XLEN  PC of ID instruction
ID_rs1_data  input  XLEN  register-file read port 1
ID_rs2_data  input  XLEN  register-file read port 2
ID_imm  input  XLEN  immediate
ID_rd  input  5  destination register
ID_opcode  input  7  opcode
ID_funct3  input  3  funct3
ID_funct7  input  7  funct7
ID_ctrl  input  6  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, is_ecall}
forward_rs1  input  2  00 regfile, 01 MEM, 10 EX, 11 reserved
forward_rs2  input  2  same encoding
EX_fwd_data  input  XLEN  ALU result of instruction now in EX
MEM_fwd_data  input  XLEN  writeback value of instruction now in MEM
EX_valid  output  1  EX holds a real instruction
EX_pc, EX_rs1_data, EX_rs2_data, EX_imm  output  XLEN each  latched fields
EX_rd  output  5  latched rd
EX_opcode  output  7  latched opcode
EX_funct3  output  3  latched funct3
EX_funct7  output  7  latched funct7
EX_ctrl  output  6  latched control, same packing as ID_ctrl
EX_is_halt  output  1  ECALL with rs1 == HALT_CODE now in EX
stall_count  output  CNT_WIDTH  cycles with is_stall && !is_flush
flush_count  output  CNT_WIDTH  cycles with is_flush

Behaviour:
- Reset (async, active-high): all outputs 0 immediately, held 0 while reset is high. The first rising edge after deassertion follows the normal rules.
- Operand select (combinational): 00 -> ID_*_data; 01 -> MEM_fwd_data; 10 -> EX_fwd_data; 11 -> ID_*_data.
- Priority each rising edge: reset > flush > stall > load.
- Load (!is_flush, !is_stall): all EX_* take ID_* values and selected operands. EX_valid = ID_valid.
  - EX_is_halt = ID_valid && is_ecall && (selected rs1 == HALT_CODE).
  - Latency 1 cycle.
- Bubble (flush or stall):
  - EX_valid, EX_ctrl and EX_is_halt load 0.
  - EX_pc, EX_rs1_data, EX_rs2_data, EX_imm, EX_rd, EX_opcode, EX_funct3 and EX_funct7 hold their previous values.
  - A bubble therefore never writes the register file or memory.
- ID_valid=0 with no stall/flush: data fields load, EX_valid=0, EX_ctrl forced to 0.
- Counters:
  - stall_count += 1 on an edge with is_stall && !is_flush.
  - flush_count += 1 on an edge with is_flush.
  - Simultaneous stall+flush counts as flush only.
  - Both saturate at all-ones (no wrap).
- Reset mid-stall: counters and outputs clear. Counting resumes from 0.
- No handshake beyond stall/flush. Upstream holds ID fields stable while is_stall is high.

Decomposition:
- Shared package/header (same place as the opcode defines): CTRL_* bit indices for the 6-bit control bundle, FWD_REGFILE/FWD_MEM/FWD_EX codes, HALT_CODE default.
- One sub-module: sat_counter (CNT_WIDTH, inc, async reset), instantiated twice.
- Operand muxes stay inline.

Test Plan:
- Reset: assert reset mid-cycle with EX_valid=1, stall_count=3 -> all outputs 0 before the next edge; stall_count=0.
- Forwarding: forward_rs1=10, EX_fwd_data=0x1234, forward_rs2=01, MEM_fwd_data=0xBEEF, ID data 0x0 -> after 1 edge EX_rs1_data=0x1234, EX_rs2_data=0xBEEF. Repeat with code 11 -> ID_rs1_data passes.
- Stall: load add (reg_write=1, EX_pc=0x100), then is_stall=1 for 2 cycles -> EX_valid=0, EX_ctrl=0, EX_pc stays 0x100; stall_count=2.
- Flush+stall together: both high for 1 edge -> bubble; flush_count=1, stall_count unchanged.
- Halt: ECALL with forward_rs1=10, EX_fwd_data=10 -> EX_is_halt=1. Same with EX_fwd_data=9 -> 0. ECALL with ID_valid=0 -> 0.
- Saturation: CNT_WIDTH=4, hold is_stall for 20 cycles -> stall_count stops at 4'hF.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: control-bundle bit indices,
// forwarding select codes and the default ECALL halt code.
package id_ex_operand_stage_pkg;

  localparam int CTRL_W          = 6;
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_ALU_SRC    = 1;
  localparam int CTRL_IS_ECALL   = 0;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_EX      = 2'b10;

  localparam int HALT_CODE_DEFAULT = 10;

  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

endpackage

// File: rtl/id_ex_operand_stage_sat_counter.sv
// Event counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: step by one unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: picks forwarded operands, latches decoded fields into
// EX, inserts bubbles on stall/flush and resolves the ECALL halt condition.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32,
  parameter int HALT_CODE = HALT_CODE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_stall,
  input  logic                 is_flush,
  input  logic                 ID_valid,
  input  logic [XLEN-1:0]      ID_pc,
  input  logic [XLEN-1:0]      ID_rs1_data,
  input  logic [XLEN-1:0]      ID_rs2_data,
  input  logic [XLEN-1:0]      ID_imm,
  input  logic [4:0]           ID_rd,
  input  logic [6:0]           ID_opcode,
  input  logic [2:0]           ID_funct3,
  input  logic [6:0]           ID_funct7,
  input  logic [CTRL_W-1:0]    ID_ctrl,
  input  logic [1:0]           forward_rs1,
  input  logic [1:0]           forward_rs2,
  input  logic [XLEN-1:0]      EX_fwd_data,
  input  logic [XLEN-1:0]      MEM_fwd_data,
  output logic                 EX_valid,
  output logic [XLEN-1:0]      EX_pc,
  output logic [XLEN-1:0]      EX_rs1_data,
  output logic [XLEN-1:0]      EX_rs2_data,
  output logic [XLEN-1:0]      EX_imm,
  output logic [4:0]           EX_rd,
  output logic [6:0]           EX_opcode,
  output logic [2:0]           EX_funct3,
  output logic [6:0]           EX_funct7,
  output logic [CTRL_W-1:0]    EX_ctrl,
  output logic                 EX_is_halt,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  // The reserved code 11 falls back to the register file value.
  function automatic logic [XLEN-1:0] sel_operand(input logic [1:0] code,
                                                  input logic [XLEN-1:0] rf_val,
                                                  input logic [XLEN-1:0] mem_val,
                                                  input logic [XLEN-1:0] ex_val);
    logic [XLEN-1:0] r;
    case (code)
      FWD_MEM: r = mem_val;
      FWD_EX:  r = ex_val;
      default: r = rf_val;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0]   rs1_sel_s, rs2_sel_s;
  logic              bubble_s;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [4:0]        rd_q, rd_d;
  logic [6:0]        opcode_q, opcode_d, funct7_q, funct7_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              halt_q, halt_d;

  // operand select and next EX register contents
  always_comb begin
    rs1_sel_s = sel_operand(forward_rs1, ID_rs1_data, MEM_fwd_data, EX_fwd_data);
    rs2_sel_s = sel_operand(forward_rs2, ID_rs2_data, MEM_fwd_data, EX_fwd_data);
    bubble_s  = is_flush | is_stall;
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    ctrl_d    = ctrl_q;
    halt_d    = halt_q;
    if (bubble_s) begin
      // bubble kills control but keeps the data fields for debug visibility
      valid_d = 1'b0;
      ctrl_d  = {CTRL_W{1'b0}};
      halt_d  = 1'b0;
    end else begin
      valid_d  = ID_valid;
      pc_d     = ID_pc;
      rs1_d    = rs1_sel_s;
      rs2_d    = rs2_sel_s;
      imm_d    = ID_imm;
      rd_d     = ID_rd;
      opcode_d = ID_opcode;
      funct3_d = ID_funct3;
      funct7_d = ID_funct7;
      ctrl_d   = ID_valid ? ID_ctrl : {CTRL_W{1'b0}};
      halt_d   = ID_valid & ID_ctrl[CTRL_IS_ECALL] & (rs1_sel_s == XLEN'(HALT_CODE));
    end
  end

  // EX stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pc_q     <= {XLEN{1'b0}};
      rs1_q    <= {XLEN{1'b0}};
      rs2_q    <= {XLEN{1'b0}};
      imm_q    <= {XLEN{1'b0}};
      rd_q     <= 5'd0;
      opcode_q <= 7'd0;
      funct3_q <= 3'd0;
      funct7_q <= 7'd0;
      ctrl_q   <= {CTRL_W{1'b0}};
      halt_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      ctrl_q   <= ctrl_d;
      halt_q   <= halt_d;
    end
  end

  assign EX_valid    = valid_q;
  assign EX_pc       = pc_q;
  assign EX_rs1_data = rs1_q;
  assign EX_rs2_data = rs2_q;
  assign EX_imm      = imm_q;
  assign EX_rd       = rd_q;
  assign EX_opcode   = opcode_q;
  assign EX_funct3   = funct3_q;
  assign EX_funct7   = funct7_q;
  assign EX_ctrl     = ctrl_q;
  assign EX_is_halt  = halt_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (is_stall & ~is_flush),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (is_flush),
    .count (flush_count)
  );

endmodule
